// File: rtl/ddr_wr_pkg.sv
// ddr_wr_pkg: shared states, counter width and burst helpers for the DDR write DQS generator
package ddr_wr_pkg;
  typedef enum logic [2:0] {IDLE, WLAT, PRE, DATA, POST} state_t;
  localparam int CNT_W = 5;
  localparam int BL_SHORT = 4;
  localparam int BL_LONG = 8;
  function automatic int data_cycles(input int bl);
    return bl / 2;
  endfunction
endpackage

// File: rtl/ddr_wr_phase_cnt.sv
// ddr_wr_phase_cnt: loadable down-counter timing each burst phase, terminal flag at count 1
module ddr_wr_phase_cnt
  import ddr_wr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt_d,
  output logic             tc
);
  logic [CNT_W-1:0] cnt;
  assign cnt_d = load ? load_val : cnt - 1'b1;
  assign tc = cnt == CNT_W'(1);
  always_ff @(posedge clk) cnt <= rst ? '0 : cnt_d;
endmodule

// File: rtl/ddr_wr_dqs_gen.sv
// ddr_wr_dqs_gen: sequences one DDR write burst (latency, preamble, data, postamble) per accepted request
module ddr_wr_dqs_gen
  import ddr_wr_pkg::*;
#(
  parameter int DQ_WIDTH = 8,
  parameter int DM_WIDTH = 1,
  parameter int WL       = 5,
  parameter int BL       = 8,
  parameter int PRE_CYC  = 1,
  parameter int POST_CYC = 1
) (
  input  logic                  SCLK,
  input  logic                  RST,
  input  logic                  WRITE,
  output logic                  READY,
  output logic                  DATA_REQ,
  input  logic [2*DQ_WIDTH-1:0] DIN,
  input  logic [2*DM_WIDTH-1:0] DMIN,
  output logic [DQ_WIDTH-1:0]   DQ_R,
  output logic [DQ_WIDTH-1:0]   DQ_F,
  output logic [DM_WIDTH-1:0]   DM_R,
  output logic [DM_WIDTH-1:0]   DM_F,
  output logic                  DQS_R,
  output logic                  DQS_F,
  output logic                  DQS_OE,
  output logic                  DQ_OE,
  output logic                  DONE,
  output logic                  ERR
);
  if (WL <= PRE_CYC || WL > 31 || (BL != BL_SHORT && BL != BL_LONG) ||
      PRE_CYC < 1 || PRE_CYC > 2 || POST_CYC < 1 || POST_CYC > 2) begin : g_bad_params
    $error("ddr_wr_dqs_gen: illegal WL/BL/PRE_CYC/POST_CYC combination");
  end
  localparam logic [CNT_W-1:0] WLAT_LEN = CNT_W'(WL - PRE_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LEN  = CNT_W'(PRE_CYC);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(data_cycles(BL));
  localparam logic [CNT_W-1:0] POST_LEN = CNT_W'(POST_CYC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  state_t           state, state_n;
  logic             load, tc;
  logic [CNT_W-1:0] load_val, cnt_d;
  ddr_wr_phase_cnt u_cnt (
    .clk(SCLK), .rst(RST), .load(load), .load_val(load_val), .cnt_d(cnt_d), .tc(tc)
  );
  always_comb begin
    state_n = state;
    load_val = '0;
    unique case (state)
      IDLE: if (WRITE) begin
        state_n = (WLAT_LEN != '0) ? WLAT : PRE;
        load_val = (WLAT_LEN != '0) ? WLAT_LEN : PRE_LEN;
      end
      WLAT: if (tc) begin
        state_n = PRE;
        load_val = PRE_LEN;
      end
      PRE: if (tc) begin
        state_n = DATA;
        load_val = DATA_LEN;
      end
      DATA: if (tc) begin
        state_n = POST;
        load_val = POST_LEN;
      end
      POST: if (tc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    load = (state_n != state) || (state_n == IDLE);
  end
  // Outputs are decoded from the next state so they are registered yet aligned to it
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state    <= IDLE;
      READY    <= 1'b1;
      DATA_REQ <= 1'b0;
      DQS_R    <= 1'b0;
      DQS_OE   <= 1'b0;
      DQ_OE    <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      DQ_R     <= '0;
      DQ_F     <= '0;
      DM_R     <= '0;
      DM_F     <= '0;
    end else begin
      state    <= state_n;
      READY    <= state_n == IDLE;
      DATA_REQ <= (state_n == PRE && cnt_d == ONE) || (state_n == DATA && cnt_d != ONE);
      DQS_R    <= state_n == DATA;
      DQS_OE   <= state_n inside {PRE, DATA, POST};
      DQ_OE    <= state_n == DATA;
      DONE     <= state_n == POST && cnt_d == ONE;
      ERR      <= WRITE && !READY;
      if (DATA_REQ) begin
        DQ_R <= DIN[DQ_WIDTH-1:0];
        DQ_F <= DIN[2*DQ_WIDTH-1:DQ_WIDTH];
        DM_R <= DMIN[DM_WIDTH-1:0];
        DM_F <= DMIN[2*DM_WIDTH-1:DM_WIDTH];
      end
    end
  end
  assign DQS_F = 1'b0;
endmodule

// File: tb/tb_ddr_wr_dqs_gen.sv
// tb_ddr_wr_dqs_gen: directed vector table plus hand sequences and a burst scoreboard for ddr_wr_dqs_gen
module tb_ddr_wr_dqs_gen;
  logic        SCLK = 1'b0, RST = 1'b1, WRITE = 1'b0;
  logic [15:0] DIN = '0;
  logic [1:0]  DMIN = '0;
  logic        ready[3], data_req[3], dqs_r[3], dqs_f[3], dqs_oe[3], dq_oe[3], done[3], err[3];
  logic        dm_r[3], dm_f[3];
  logic [7:0]  dq_r[3], dq_f[3];
  int          n_chk = 0, n_fail = 0;
  always #5 SCLK = ~SCLK;

  ddr_wr_dqs_gen u0 (
    .SCLK(SCLK), .RST(RST), .WRITE(WRITE), .READY(ready[0]), .DATA_REQ(data_req[0]),
    .DIN(DIN), .DMIN(DMIN), .DQ_R(dq_r[0]), .DQ_F(dq_f[0]), .DM_R(dm_r[0]), .DM_F(dm_f[0]),
    .DQS_R(dqs_r[0]), .DQS_F(dqs_f[0]), .DQS_OE(dqs_oe[0]), .DQ_OE(dq_oe[0]),
    .DONE(done[0]), .ERR(err[0])
  );
  ddr_wr_dqs_gen #(.WL(3), .BL(4), .PRE_CYC(2), .POST_CYC(2)) u1 (
    .SCLK(SCLK), .RST(RST), .WRITE(WRITE), .READY(ready[1]), .DATA_REQ(data_req[1]),
    .DIN(DIN), .DMIN(DMIN), .DQ_R(dq_r[1]), .DQ_F(dq_f[1]), .DM_R(dm_r[1]), .DM_F(dm_f[1]),
    .DQS_R(dqs_r[1]), .DQS_F(dqs_f[1]), .DQS_OE(dqs_oe[1]), .DQ_OE(dq_oe[1]),
    .DONE(done[1]), .ERR(err[1])
  );
  ddr_wr_dqs_gen #(.WL(9), .BL(8), .PRE_CYC(2), .POST_CYC(1)) u2 (
    .SCLK(SCLK), .RST(RST), .WRITE(WRITE), .READY(ready[2]), .DATA_REQ(data_req[2]),
    .DIN(DIN), .DMIN(DMIN), .DQ_R(dq_r[2]), .DQ_F(dq_f[2]), .DM_R(dm_r[2]), .DM_F(dm_f[2]),
    .DQS_R(dqs_r[2]), .DQS_F(dqs_f[2]), .DQS_OE(dqs_oe[2]), .DQ_OE(dq_oe[2]),
    .DONE(done[2]), .ERR(err[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // control bits in order {READY, DATA_REQ, DQS_OE, DQ_OE, DQS_R, DONE, ERR}
  function automatic logic [6:0] ctl(input int k);
    return {ready[k], data_req[k], dqs_oe[k], dq_oe[k], dqs_r[k], done[k], err[k]};
  endfunction

  typedef struct packed {
    logic        write;
    logic [15:0] din;
    logic [1:0]  dmin;
    logic [6:0]  ctl;
    logic [7:0]  dqr;
    logic [7:0]  dqf;
    logic        dmr;
    logic        dmf;
  } vec_t;
  vec_t tbl[21];

  function automatic vec_t v(input logic w, input logic [15:0] d, input logic [1:0] m,
                             input logic [6:0] c, input logic [7:0] qr, input logic [7:0] qf,
                             input logic mr, input logic mf);
    return '{write: w, din: d, dmin: m, ctl: c, dqr: qr, dqf: qf, dmr: mr, dmf: mf};
  endfunction

  // u1 (WL=3 BL=4 PRE=2 POST=2) single burst, cycles 0..7
  localparam logic [6:0] EXP5[8] = '{7'b1000000, 7'b0010000, 7'b0110000, 7'b0111100,
                                     7'b0011100, 7'b0010000, 7'b0010010, 7'b1000000};
  localparam int BLH[3] = '{4, 2, 4};
  localparam int TOT[3] = '{6, 6, 7};

  logic        sb_on = 1'b0;
  logic        cap_req[3];
  logic [15:0] cap_din;
  logic [1:0]  cap_dm;
  int          sb_oe[3] = '{0, 0, 0}, sb_doe[3] = '{0, 0, 0}, sb_done[3] = '{0, 0, 0};
  int          sb_err = 0;
  int          oe, doe, done_at;

  always @(posedge SCLK) begin
    cap_din <= DIN;
    cap_dm  <= DMIN;
    for (int k = 0; k < 3; k++) cap_req[k] <= data_req[k];
  end

  always @(negedge SCLK) begin
    if (sb_on) begin
      for (int k = 0; k < 3; k++) begin
        if (cap_req[k]) begin
          chk($sformatf("sb_dq_r[%0d]", k), 32'(dq_r[k]), 32'(cap_din[7:0]));
          chk($sformatf("sb_dq_f[%0d]", k), 32'(dq_f[k]), 32'(cap_din[15:8]));
          chk($sformatf("sb_dm_r[%0d]", k), 32'(dm_r[k]), 32'(cap_dm[0]));
          chk($sformatf("sb_dm_f[%0d]", k), 32'(dm_f[k]), 32'(cap_dm[1]));
        end
        chk($sformatf("sb_dqs_r_vs_dq_oe[%0d]", k), 32'(dqs_r[k]), 32'(dq_oe[k]));
        if (dqs_oe[k]) sb_oe[k]++;
        if (dq_oe[k]) sb_doe[k]++;
        if (done[k]) begin
          chk($sformatf("sb_dqs_oe_len[%0d]", k), sb_oe[k], TOT[k]);
          chk($sformatf("sb_dq_oe_len[%0d]", k), sb_doe[k], BLH[k]);
          sb_done[k]++;
          sb_oe[k] = 0;
          sb_doe[k] = 0;
        end
      end
      if (err[0]) sb_err++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = v(1'b1, 16'h0000, 2'b00, 7'b1000000, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[1]  = v(1'b0, 16'h0000, 2'b00, 7'b0000000, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[2]  = tbl[1];
    tbl[3]  = v(1'b1, 16'h0000, 2'b00, 7'b0000000, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[4]  = v(1'b0, 16'hA155, 2'b00, 7'b0110001, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[5]  = v(1'b0, 16'hB266, 2'b10, 7'b0111100, 8'h55, 8'hA1, 1'b0, 1'b0);
    tbl[6]  = v(1'b0, 16'hC377, 2'b00, 7'b0111100, 8'h66, 8'hB2, 1'b0, 1'b1);
    tbl[7]  = v(1'b0, 16'hD488, 2'b00, 7'b0111100, 8'h77, 8'hC3, 1'b0, 1'b0);
    tbl[8]  = v(1'b0, 16'h0000, 2'b00, 7'b0011100, 8'h88, 8'hD4, 1'b0, 1'b0);
    tbl[9]  = v(1'b0, 16'h0000, 2'b00, 7'b0010010, 8'h88, 8'hD4, 1'b0, 1'b0);
    tbl[10] = v(1'b1, 16'h0000, 2'b00, 7'b1000000, 8'h88, 8'hD4, 1'b0, 1'b0);
    for (int i = 11; i <= 13; i++) tbl[i] = v(1'b0, 16'h0, 2'b0, 7'b0000000, 8'h88, 8'hD4, 1'b0, 1'b0);
    tbl[14] = v(1'b0, 16'h0000, 2'b00, 7'b0110000, 8'h88, 8'hD4, 1'b0, 1'b0);
    for (int i = 15; i <= 17; i++) tbl[i] = v(1'b0, 16'h0, 2'b0, 7'b0111100, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[18] = v(1'b0, 16'h0000, 2'b00, 7'b0011100, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[19] = v(1'b0, 16'h0000, 2'b00, 7'b0010010, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[20] = v(1'b0, 16'h0000, 2'b00, 7'b1000000, 8'h00, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge SCLK);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ctl[%0d]", k), 32'(ctl(k)), 32'(7'b1000000));
      chk($sformatf("reset_dqs_f[%0d]", k), 32'(dqs_f[k]), 0);
      chk($sformatf("reset_dq[%0d]", k), 32'({dq_r[k], dq_f[k], dm_r[k], dm_f[k]}), 0);
    end
    RST = 1'b0;

    // default burst with data, a busy WRITE at cycle 3 and a second burst at cycle 10
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("tbl_ctl[%0d]", i), 32'(ctl(0)), 32'(tbl[i].ctl));
      chk($sformatf("tbl_dq_r[%0d]", i), 32'(dq_r[0]), 32'(tbl[i].dqr));
      chk($sformatf("tbl_dq_f[%0d]", i), 32'(dq_f[0]), 32'(tbl[i].dqf));
      chk($sformatf("tbl_dm[%0d]", i), 32'({dm_r[0], dm_f[0]}), 32'({tbl[i].dmr, tbl[i].dmf}));
      WRITE = tbl[i].write;
      DIN = tbl[i].din;
      DMIN = tbl[i].dmin;
      @(negedge SCLK);
    end
    WRITE = 1'b0;
    DIN = '0;
    DMIN = '0;
    repeat (2) @(negedge SCLK);

    // reset lands in the first DATA cycle, then a fresh burst follows immediately
    DIN = 16'h5AA5;
    WRITE = 1'b1;
    @(negedge SCLK);
    WRITE = 1'b0;
    repeat (4) @(negedge SCLK);
    chk("rst_pre_dq_oe", 32'(dq_oe[0]), 1);
    chk("rst_pre_dq_r", 32'(dq_r[0]), 32'h A5);
    RST = 1'b1;
    @(negedge SCLK);
    chk("rst_ctl", 32'(ctl(0)), 32'(7'b1000000));
    chk("rst_dq_r", 32'(dq_r[0]), 0);
    RST = 1'b0;
    WRITE = 1'b1;
    @(negedge SCLK);
    WRITE = 1'b0;
    oe = 0;
    doe = 0;
    done_at = -1;
    for (int c = 7; c <= 16; c++) begin
      if (c == 15) chk("after_rst_ready_busy", 32'(ready[0]), 0);
      if (c == 16) chk("after_rst_ready_idle", 32'(ready[0]), 1);
      if (dqs_oe[0]) oe++;
      if (dq_oe[0]) doe++;
      if (done[0]) done_at = c;
      @(negedge SCLK);
    end
    chk("after_rst_dqs_oe_len", oe, 6);
    chk("after_rst_dq_oe_len", doe, 4);
    chk("after_rst_done_cycle", done_at, 15);
    repeat (6) @(negedge SCLK);

    // shortest legal latency: no WLAT, two-cycle preamble and postamble
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("short_ctl[%0d]", c), 32'(ctl(1)), 32'(EXP5[c]));
      WRITE = (c == 0);
      @(negedge SCLK);
    end
    WRITE = 1'b0;
    repeat (16) @(negedge SCLK);

    // WRITE held high with random data across all three parameter sets
    sb_on = 1'b1;
    for (int c = 0; c < 80; c++) begin
      WRITE = (c < 60);
      DIN = 16'($urandom);
      DMIN = 2'($urandom);
      @(negedge SCLK);
    end
    sb_on = 1'b0;
    WRITE = 1'b0;
    chk("held_bursts[0]", sb_done[0], 6);
    chk("held_bursts[1]", sb_done[1], 9);
    chk("held_bursts[2]", sb_done[2], 5);
    chk("held_err_pulses", sb_err, 54);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
